// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// IF/ID entry layout, reset PC default and the NOP encoding.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // One fetched instruction together with the word address it came from.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR};

  // Jump wins over a simultaneous taken branch.
  function automatic logic [31:0] redirect_target(
    input logic        jump,
    input logic [31:0] jump_target,
    input logic [31:0] branch_target
  );
    return jump ? jump_target : branch_target;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: redirect target has priority over the
// sequential advance supplied by the external increment adder.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  input  logic        i_advance,
  input  logic [31:0] i_adder_out,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= i_target;
    end else if (i_advance) begin
      r_pc <= i_adder_out;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request, buffers one
// instruction across downstream stalls and drains requests aborted by redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_out,
  input  logic [31:0] adder_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  fetch_entry_t r_ifid;
  fetch_entry_t r_hold;
  logic [31:0]  r_drain_addr;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_ifid_new;
  logic         w_ifid_from_hold;
  logic         w_hold_capture;
  logic         w_drain_save;
  logic         w_advance;

  assign w_redirect = jump | branch_taken;
  assign w_target   = redirect_target(jump, jump_target, branch_target);
  assign w_advance  = w_ifid_new | w_hold_capture;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_redirect (w_redirect),
    .i_target   (w_target),
    .i_advance  (w_advance),
    .i_adder_out(adder_out),
    .o_pc       (pc_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    imem_req         = 1'b0;
    imem_addr        = pc_out;
    w_ifid_new       = 1'b0;
    w_ifid_from_hold = 1'b0;
    w_hold_capture   = 1'b0;
    w_drain_save     = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (w_redirect) begin
          // A request without its transfer cannot be withdrawn; finish it in DRAIN.
          if (!imem_ready) begin
            w_state_nxt  = ST_DRAIN;
            w_drain_save = 1'b1;
          end
        end else if (imem_ready) begin
          if (stall) begin
            w_hold_capture = 1'b1;
            w_state_nxt    = ST_HOLD;
          end else begin
            w_ifid_new = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_redirect) begin
          w_state_nxt = ST_FETCH;
        end else if (!stall) begin
          w_ifid_from_hold = r_hold.valid;
          w_state_nxt      = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = r_drain_addr;
        if (imem_ready) begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_addr <= 32'h0;
    end else if (w_drain_save) begin
      r_drain_addr <= pc_out;
    end
  end

  // Redirect overrides stall; a stall freezes the whole register otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid <= EMPTY_ENTRY;
    end else if (w_redirect) begin
      r_ifid.valid <= 1'b0;
    end else if (w_ifid_new) begin
      r_ifid <= '{valid: 1'b1, pc: pc_out, instr: imem_rdata};
    end else if (w_ifid_from_hold) begin
      r_ifid <= '{valid: 1'b1, pc: r_hold.pc, instr: r_hold.instr};
    end else if (!stall) begin
      r_ifid.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= EMPTY_ENTRY;
    end else if (w_redirect) begin
      r_hold.valid <= 1'b0;
    end else if (w_hold_capture) begin
      r_hold <= '{valid: 1'b1, pc: pc_out, instr: imem_rdata};
    end else if (w_ifid_from_hold) begin
      r_hold.valid <= 1'b0;
    end
  end

  assign ifid_valid = r_ifid.valid;
  assign ifid_pc    = r_ifid.pc;
  assign ifid_instr = r_ifid.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared cycle by cycle against a flag-based behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] adder_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign adder_out  = pc_out + 32'd1;
  assign imem_rdata = mem_word(imem_addr);

  fetch_unit #(
    .RESET_PC(RST_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .pc_out       (pc_out),
    .adder_out    (adder_out),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr)
  );

  // Behavioural model: "booting", "draining an aborted request" and
  // "holding one stalled instruction" are independent flags; otherwise fetching.
  logic [31:0] m_pc, m_drain_addr, m_hold_pc, m_hold_instr;
  logic [31:0] m_ifid_pc, m_ifid_instr;
  bit          m_boot, m_drain, m_hold, m_ifid_valid;

  function automatic bit m_req();
    return !m_boot && !m_hold;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_drain ? m_drain_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_drain_addr = 32'h0; m_hold_pc = 32'h0; m_hold_instr = 32'h0;
    m_ifid_pc = 32'h0; m_ifid_instr = 32'h0;
    m_boot = 1'b1; m_drain = 1'b0; m_hold = 1'b0; m_ifid_valid = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit j, input logic [31:0] jt,
                            input bit b, input logic [31:0] bt, input bit r);
    bit          fetching, xfer;
    logic [31:0] addr;
    fetching = !m_boot && !m_hold && !m_drain;
    addr     = m_addr();
    xfer     = m_req() && r;
    if (j || b) begin
      m_ifid_valid = 1'b0;
      m_hold       = 1'b0;
      if (fetching && !xfer) begin
        m_drain      = 1'b1;
        m_drain_addr = m_pc;
      end else if (m_drain && xfer) begin
        m_drain = 1'b0;
      end
      m_boot = 1'b0;
      m_pc   = j ? jt : bt;
    end else if (m_boot) begin
      m_boot = 1'b0;
      if (!s) m_ifid_valid = 1'b0;
    end else if (m_drain) begin
      if (xfer) m_drain = 1'b0;
      if (!s) m_ifid_valid = 1'b0;
    end else if (m_hold) begin
      if (!s) begin
        m_ifid_valid = 1'b1; m_ifid_pc = m_hold_pc; m_ifid_instr = m_hold_instr;
        m_hold = 1'b0;
      end
    end else if (xfer) begin
      m_pc = m_pc + 32'd1;
      if (!s) begin
        m_ifid_valid = 1'b1; m_ifid_pc = addr; m_ifid_instr = mem_word(addr);
      end else begin
        m_hold = 1'b1; m_hold_pc = addr; m_hold_instr = mem_word(addr);
      end
    end else if (!s) begin
      m_ifid_valid = 1'b0;
    end
  endtask

  // Called at a falling edge; applies inputs across one rising edge.
  task automatic drive_cycle(input bit s, input bit j, input logic [31:0] jt,
                             input bit b, input logic [31:0] bt, input bit r);
    stall = s; jump = j; jump_target = jt; branch_taken = b; branch_target = bt; imem_ready = r;
    @(posedge clk);
    model_step(s, j, jt, b, bt, r);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
    jump_target = 32'h0; branch_target = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL rst_pc: got %h want %h", pc_out, RST_PC); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ifid_valid); end
    checks++; if (ifid_pc !== 32'h0 || ifid_instr !== 32'h0) begin
      errors++; $display("FAIL rst_ifid: got pc %h instr %h want 0/0", ifid_pc, ifid_instr);
    end
    rst_n = 1'b1;
    model_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b want 0", imem_req); end
    drive_cycle(0, 0, 0, 0, 0, 1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL seq_addr0: got req %b addr %h want 1/00000010", imem_req, imem_addr);
    end
    for (int k = 1; k <= 2; k++) begin
      drive_cycle(0, 0, 0, 0, 0, 1);
      checks++; if (imem_addr !== 32'h10 + k) begin
        errors++; $display("FAIL seq_addr%0d: got %h want %h", k, imem_addr, 32'h10 + k);
      end
      checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h10 + k - 1 ||
                    ifid_instr !== mem_word(32'h10 + k - 1)) begin
        errors++; $display("FAIL seq_ifid%0d: got v%b pc %h instr %h want pc %h", k, ifid_valid,
                           ifid_pc, ifid_instr, 32'h10 + k - 1);
      end
    end
  endtask

  task automatic test_stall_hold();
    drive_cycle(0, 1, 32'h5, 0, 0, 1);
    checks++; if (imem_addr !== 32'h5) begin errors++; $display("FAIL hold_setup: got %h want 00000005", imem_addr); end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1, 0, 0, 0, 0, 1);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req%0d: got %b want 0", k, imem_req); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL hold_frozen%0d: got %b want 0", k, ifid_valid); end
    end
    drive_cycle(0, 0, 0, 0, 0, 1);
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h5 || ifid_instr !== mem_word(32'h5)) begin
      errors++; $display("FAIL hold_release: got v%b pc %h want 1/00000005", ifid_valid, ifid_pc);
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h6) begin
      errors++; $display("FAIL hold_next_addr: got req %b addr %h want 1/00000006", imem_req, imem_addr);
    end
    drive_cycle(0, 0, 0, 0, 0, 1);
    checks++; if (ifid_pc !== 32'h6 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL hold_next_ifid: got v%b pc %h want 1/00000006", ifid_valid, ifid_pc);
    end
  endtask

  task automatic test_jump_priority();
    drive_cycle(0, 1, 32'h40, 1, 32'h80, 1);
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL prio_addr: got %h want 00000040", imem_addr); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL prio_valid: got %b want 0", ifid_valid); end
  endtask

  task automatic test_wait_redirect();
    drive_cycle(0, 1, 32'h7, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h7) begin
      errors++; $display("FAIL wait_c1: got req %b addr %h want 1/00000007", imem_req, imem_addr);
    end
    drive_cycle(0, 0, 0, 1, 32'h20, 0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h7) begin
        errors++; $display("FAIL wait_drain%0d: got req %b addr %h want 1/00000007", k, imem_req, imem_addr);
      end
      if (k < 2) drive_cycle(0, 0, 0, 0, 0, 0);
    end
    checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL wait_pc: got %h want 00000020", pc_out); end
    drive_cycle(0, 0, 0, 0, 0, 1);
    checks++; if (imem_addr !== 32'h20 || ifid_valid !== 1'b0) begin
      errors++; $display("FAIL wait_dropped: got addr %h valid %b want 00000020/0", imem_addr, ifid_valid);
    end
    drive_cycle(0, 0, 0, 0, 0, 1);
    checks++; if (ifid_pc !== 32'h20 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL wait_after: got v%b pc %h want 1/00000020", ifid_valid, ifid_pc);
    end
  endtask

  task automatic test_wrap();
    drive_cycle(0, 1, 32'hFFFF_FFFF, 0, 0, 1);
    checks++; if (imem_addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_setup: got %h want ffffffff", imem_addr); end
    drive_cycle(0, 0, 0, 0, 0, 1);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr); end
    checks++; if (ifid_pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_ifid: got %h want ffffffff", ifid_pc); end
  endtask

  task automatic test_reset_mid_drain();
    drive_cycle(0, 0, 0, 1, 32'h33, 0);
    checks++; if (pc_out !== 32'h33 || imem_req !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got pc %h req %b want 00000033/1", pc_out, imem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || pc_out !== RST_PC || imem_addr !== RST_PC) begin
      errors++; $display("FAIL mid_async: got req %b pc %h addr %h want 0/%h", imem_req, pc_out, imem_addr, RST_PC);
    end
    checks++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== 32'h0) begin
      errors++; $display("FAIL mid_ifid: got v%b pc %h instr %h want 0/0/0", ifid_valid, ifid_pc, ifid_instr);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_boot: got %b want 0", imem_req); end
    drive_cycle(0, 0, 0, 0, 0, 1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL mid_refetch: got req %b addr %h want 1/%h", imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_random();
    bit s, j, b, r;
    logic [31:0] jt, bt;
    for (int n = 0; n < 400; n++) begin
      checks++; if (imem_req !== m_req()) begin
        errors++; $display("FAIL rnd_req @%0d: got %b want %b", n, imem_req, m_req());
      end
      checks++; if (imem_addr !== m_addr()) begin
        errors++; $display("FAIL rnd_addr @%0d: got %h want %h", n, imem_addr, m_addr());
      end
      checks++; if (pc_out !== m_pc) begin
        errors++; $display("FAIL rnd_pc @%0d: got %h want %h", n, pc_out, m_pc);
      end
      checks++; if (ifid_valid !== m_ifid_valid) begin
        errors++; $display("FAIL rnd_valid @%0d: got %b want %b", n, ifid_valid, m_ifid_valid);
      end
      checks++; if (ifid_pc !== m_ifid_pc || ifid_instr !== m_ifid_instr) begin
        errors++; $display("FAIL rnd_ifid @%0d: got %h/%h want %h/%h", n, ifid_pc, ifid_instr,
                           m_ifid_pc, m_ifid_instr);
      end
      s  = ($urandom_range(2, 0) == 0);
      j  = ($urandom_range(15, 0) == 0);
      b  = ($urandom_range(11, 0) == 0);
      r  = ($urandom_range(2, 0) != 0);
      jt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : $urandom;
      bt = $urandom;
      drive_cycle(s, j, jt, b, bt, r);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_stall_hold();
    test_jump_priority();
    test_wait_redirect();
    test_wrap();
    test_reset_mid_drain();
    test_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
